// File: rtl/sr_ff_async_r_pkg.sv
// Shared definitions for SR-style status registers.
// Holds the forbidden-input (s=r=1) policy encodings and the per-bit
// next-state function that every SR-flavoured register reuses.
package sr_ff_async_r_pkg;

    // Resolution of the forbidden s=r=1 input combination
    localparam int SR_FORBID_HOLD = 0;  // keep previous value
    localparam int SR_FORBID_SET  = 1;  // set-dominant
    localparam int SR_FORBID_CLR  = 2;  // reset-dominant

    // Next state of a single SR bit given current state, requests and policy.
    // An unknown policy falls back to hold so the cell never invents a value.
    function automatic logic sr_next(
        input logic q,
        input logic s,
        input logic r,
        input int   policy
    );
        logic q_next_s;
        q_next_s = q;
        case ({s, r})
            2'b00: q_next_s = q;
            2'b01: q_next_s = 1'b0;
            2'b10: q_next_s = 1'b1;
            2'b11: begin
                case (policy)
                    SR_FORBID_HOLD: q_next_s = q;
                    SR_FORBID_SET:  q_next_s = 1'b1;
                    SR_FORBID_CLR:  q_next_s = 1'b0;
                    default:        q_next_s = q;
                endcase
            end
            default: q_next_s = q;
        endcase
        return q_next_s;
    endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// Single SR flip-flop cell.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset, highest priority
//   s, r   - set / clear requests, sampled only at posedge clk
//   q      - registered state
module sr_ff_bit
    import sr_ff_async_r_pkg::*;
#(
    parameter int FORBID_POLICY = SR_FORBID_HOLD
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_r;
    logic q_next_s;

    // Next-state decode from the shared SR function
    always_comb begin
        q_next_s = sr_next(q_r, s, r, FORBID_POLICY);
    end

    // State register; reset wins over any set/clear request
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= 1'b0;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sr_ff_async_r.sv
// Vector of independent clocked SR flip-flops with complementary outputs.
// The historical name suggests an asynchronous reset; reset is in fact
// synchronous and the name is kept so existing instances keep working.
// Positional port order (s, r, reset, clk, q, qbar) is relied on by
// existing instantiations and must not change.
// Ports:
//   s     [WIDTH] - per-bit set request
//   r     [WIDTH] - per-bit clear request
//   reset         - synchronous active-high reset (q -> 0)
//   clk           - rising-edge clock
//   q     [WIDTH] - registered state
//   qbar  [WIDTH] - ~q, derived from the same register so q != qbar always
module sr_ff_async_r
    import sr_ff_async_r_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int FORBID_POLICY = SR_FORBID_HOLD
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             reset,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    // Reject unsupported forbidden-input policies at elaboration
    if ((FORBID_POLICY != SR_FORBID_HOLD) &&
        (FORBID_POLICY != SR_FORBID_SET)  &&
        (FORBID_POLICY != SR_FORBID_CLR)) begin : g_bad_policy
        $error("sr_ff_async_r: illegal FORBID_POLICY %0d", FORBID_POLICY);
    end

    logic [WIDTH-1:0] q_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_ff_bit #(
            .FORBID_POLICY(FORBID_POLICY)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q_s[i])
        );
    end

    assign q    = q_s;
    assign qbar = ~q_s;

endmodule

// File: tb/tb_sr_ff_async_r.sv
// Directed bench for sr_ff_async_r: one-bit instances for each forbidden
// policy plus a four-bit instance, all sharing clock and reset.
module tb_sr_ff_async_r;

    logic       clk;
    logic       reset;
    logic       s0, r0, s1, r1, s2, r2;
    logic [3:0] s4, r4;
    logic       q0, qb0, q1, qb1, q2, qb2;
    logic [3:0] q4, qb4;

    int n_checks = 0;
    int n_pass   = 0;

    sr_ff_async_r #(.WIDTH(1), .FORBID_POLICY(0)) u_d0 (
        .s(s0), .r(r0), .reset(reset), .clk(clk), .q(q0), .qbar(qb0));
    sr_ff_async_r #(.WIDTH(1), .FORBID_POLICY(1)) u_d1 (
        .s(s1), .r(r1), .reset(reset), .clk(clk), .q(q1), .qbar(qb1));
    sr_ff_async_r #(.WIDTH(1), .FORBID_POLICY(2)) u_d2 (
        .s(s2), .r(r2), .reset(reset), .clk(clk), .q(q2), .qbar(qb2));
    sr_ff_async_r #(.WIDTH(4), .FORBID_POLICY(0)) u_d4 (
        .s(s4), .r(r4), .reset(reset), .clk(clk), .q(q4), .qbar(qb4));

    // Free-running clock, first rising edge at t=5
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        s0 = 1'b0; r0 = 1'b0; s1 = 1'b0; r1 = 1'b0; s2 = 1'b0; r2 = 1'b0;
        s4 = 4'b0000; r4 = 4'b0000;

        // Reset state
        step();
        check("rst_q0",   {3'b000, q0},  4'b0000);
        check("rst_qb0",  {3'b000, qb0}, 4'b0001);
        check("rst_q4",   q4,  4'b0000);
        check("rst_qb4",  qb4, 4'b1111);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("idle_q0",  {3'b000, q0},  4'b0000);
            check("idle_qb0", {3'b000, qb0}, 4'b0001);
        end

        // Set, hold, clear
        s0 = 1'b1; step();
        check("set_q0",  {3'b000, q0},  4'b0001);
        check("set_qb0", {3'b000, qb0}, 4'b0000);
        s0 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_q0", {3'b000, q0}, 4'b0001);
        end
        r0 = 1'b1; step();
        check("clr_q0",  {3'b000, q0},  4'b0000);
        check("clr_qb0", {3'b000, qb0}, 4'b0001);
        r0 = 1'b0;

        // Forbidden input, hold policy from q=1
        s0 = 1'b1; step();
        r0 = 1'b1; step();
        check("fb_hold_q",  {3'b000, q0},  4'b0001);
        check("fb_hold_qb", {3'b000, qb0}, 4'b0000);
        s0 = 1'b0; r0 = 1'b0;

        // Forbidden input, set-dominant from q=0
        check("fb_set_pre", {3'b000, q1}, 4'b0000);
        s1 = 1'b1; r1 = 1'b1; step();
        check("fb_set_q",  {3'b000, q1},  4'b0001);
        check("fb_set_qb", {3'b000, qb1}, 4'b0000);
        s1 = 1'b0; r1 = 1'b0;

        // Forbidden input, reset-dominant from q=1
        s2 = 1'b1; step();
        check("fb_clr_pre", {3'b000, q2}, 4'b0001);
        r2 = 1'b1; step();
        check("fb_clr_q",  {3'b000, q2},  4'b0000);
        check("fb_clr_qb", {3'b000, qb2}, 4'b0001);
        s2 = 1'b0; r2 = 1'b0;

        // Reset beats a simultaneous set, then set applies once reset drops
        s0 = 1'b1; reset = 1'b1; step();
        check("rstpri_q",  {3'b000, q0},  4'b0000);
        check("rstpri_qb", {3'b000, qb0}, 4'b0001);
        reset = 1'b0; step();
        check("rstrel_q", {3'b000, q0}, 4'b0001);
        s0 = 1'b0;

        // Pulses wholly between edges are ignored
        s2 = 1'b1; #2; s2 = 1'b0; step();
        check("glitch_s", {3'b000, q2}, 4'b0000);
        r0 = 1'b1; #2; r0 = 1'b0; step();
        check("glitch_r", {3'b000, q0}, 4'b0001);
        reset = 1'b1; #2; reset = 1'b0; step();
        check("glitch_rst", {3'b000, q0}, 4'b0001);

        // Independent bits in a 4-bit bank
        s4 = 4'b0101; r4 = 4'b0000; step();
        check("w4_q_a",  q4,  4'b0101);
        check("w4_qb_a", qb4, 4'b1010);
        s4 = 4'b0010; r4 = 4'b0100; step();
        check("w4_q_b",  q4,  4'b0011);
        check("w4_qb_b", qb4, 4'b1100);
        s4 = 4'b0000; r4 = 4'b0000;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
